// File: rtl/ahb_fir_pkg.sv
// Shared codes, register offsets and status bit positions for the AHB-Lite FIR slave.
package ahb_fir_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HSIZE_BYTE = 1'b0;
  localparam logic HSIZE_HALF = 1'b1;

  localparam int ADDR_STATUS = 0;
  localparam int ADDR_RESULT = 2;
  localparam int ADDR_SAMPLE = 4;
  localparam int ADDR_COEFF0 = 6;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_ERR_BIT   = 8;

  typedef enum logic [1:0] {
    RESP_OKAY = 2'd0,
    RESP_ERR1 = 2'd1,
    RESP_ERR2 = 2'd2
  } err_state_t;

  // Byte-lane write merge: even byte address owns [7:0], odd owns [15:8].
  function automatic logic [15:0] lane_merge(input logic [15:0] old_val,
                                             input logic [15:0] wdata,
                                             input logic        half,
                                             input logic        odd);
    if (half)     return wdata;
    else if (odd) return {wdata[15:8], old_val[7:0]};
    else          return {old_val[15:8], wdata[7:0]};
  endfunction
endpackage

// File: rtl/ahb_fir_sample_fifo.sv
// Synchronous sample FIFO with wrap-around pointers; push while full is legal only with a pop.
module ahb_fir_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ahb_fir_slave_param.sv
// AHB-Lite slave for the FIR core: sample FIFO, coefficient bank, status/result/conf registers,
// FIFO-full wait states and two-cycle ERROR responses.
module ahb_fir_slave_param
  import ahb_fir_pkg::*;
#(
  parameter int NUM_COEFF  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 5,
  parameter int CNUM_W     = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hsize,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [15:0]       hwdata,
  output logic [15:0]       hrdata,
  output logic              hresp,
  output logic              hready,
  input  logic              modwait,
  input  logic              err,
  input  logic [15:0]       fir_out,
  output logic [15:0]       sample_data,
  output logic              data_ready,
  input  logic              sample_ack,
  input  logic [CNUM_W-1:0] coefficient_num,
  output logic [15:0]       fir_coefficient,
  output logic              new_coefficient_set,
  input  logic              clear_new_coefficient
);
  localparam int CONF_ADDR = ADDR_COEFF0 + 2 * NUM_COEFF;
  localparam int CONF_HIDX = CONF_ADDR / 2;
  localparam int COEF_HIDX = ADDR_COEFF0 / 2;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  err_state_t        err_state, err_next;
  logic              vld_p1, write_p1, size_p1;
  logic [ADDR_W-1:0] addr_p1;

  logic [15:0] coeff [NUM_COEFF];
  logic [15:0] result_q;
  logic [7:0]  staged;

  logic        active, addr_err;
  logic [31:0] addr_p0_ext, addr_p1_ext, hidx_p1;
  logic        push_target, commit, push, pop, stage_wr, conf_set;
  logic [15:0] push_data, fifo_head, head_gated, reg_val, status;
  logic        fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign addr_p0_ext = 32'(haddr);
  assign addr_p1_ext = 32'(addr_p1);
  assign hidx_p1     = 32'(addr_p1[ADDR_W-1:1]);

  assign active   = hsel & htrans[1] & hready;
  assign addr_err = (hwrite && addr_p0_ext < 32'(ADDR_SAMPLE)) ||
                    (addr_p0_ext >= 32'(CONF_ADDR + 2)) ||
                    (hsize == HSIZE_HALF && haddr[0]);

  // Data phase decode
  assign push_target = vld_p1 & write_p1 &
                       ((size_p1 == HSIZE_HALF && addr_p1_ext == 32'(ADDR_SAMPLE)) ||
                        (size_p1 == HSIZE_BYTE && addr_p1_ext == 32'(ADDR_SAMPLE + 1)));
  assign hready    = (err_state != RESP_ERR1) && !(push_target && fifo_full && !sample_ack);
  assign hresp     = (err_state != RESP_OKAY);
  assign commit    = vld_p1 & write_p1 & hready;
  assign push      = push_target & hready;
  assign push_data = size_p1 ? hwdata : {hwdata[15:8], staged};
  assign pop       = sample_ack & ~fifo_empty;
  assign stage_wr  = commit && size_p1 == HSIZE_BYTE && addr_p1_ext == 32'(ADDR_SAMPLE);
  assign conf_set  = commit && hidx_p1 == 32'(CONF_HIDX) &&
                     (size_p1 ? hwdata[0] : (!addr_p1[0] && hwdata[0]));

  assign head_gated  = fifo_empty ? 16'h0000 : fifo_head;
  assign sample_data = head_gated;
  assign data_ready  = ~fifo_empty;

  ahb_fir_sample_fifo #(.DATA_W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status = 16'h0000;
    status[STAT_BUSY_BIT]  = modwait | new_coefficient_set;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_ERR_BIT]   = err;
  end

  always_comb begin
    reg_val = 16'h0000;
    if (hidx_p1 == 32'(ADDR_STATUS / 2))      reg_val = status;
    else if (hidx_p1 == 32'(ADDR_RESULT / 2)) reg_val = result_q;
    else if (hidx_p1 == 32'(ADDR_SAMPLE / 2)) reg_val = head_gated;
    else if (hidx_p1 == 32'(CONF_HIDX))       reg_val = {15'h0000, new_coefficient_set};
    else begin
      for (int k = 0; k < NUM_COEFF; k++)
        if (hidx_p1 == 32'(COEF_HIDX + k)) reg_val = coeff[k];
    end
  end

  always_comb begin
    hrdata = 16'h0000;
    if (vld_p1 && !write_p1) begin
      if (size_p1 == HSIZE_HALF) hrdata = reg_val;
      else if (addr_p1[0])       hrdata = {reg_val[15:8], 8'h00};
      else                       hrdata = {8'h00, reg_val[7:0]};
    end
  end

  always_comb begin
    fir_coefficient = 16'h0000;
    if (32'(coefficient_num) < 32'(NUM_COEFF)) fir_coefficient = coeff[coefficient_num];
  end

  // ERR2 still accepts a new address phase, so a fresh error re-enters ERR1
  always_comb begin
    err_next = RESP_OKAY;
    if (err_state == RESP_ERR1)  err_next = RESP_ERR2;
    else if (active && addr_err) err_next = RESP_ERR1;
  end

  // Address phase -> data phase register stage
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_state <= RESP_OKAY;
      vld_p1    <= 1'b0;
      write_p1  <= 1'b0;
      size_p1   <= 1'b0;
      addr_p1   <= '0;
    end else begin
      err_state <= err_next;
      if (hready) begin
        vld_p1   <= active & ~addr_err;
        write_p1 <= hwrite;
        size_p1  <= hsize;
        addr_p1  <= haddr;
      end
    end
  end

  // Register commit at the edge that ends the data phase
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      result_q            <= 16'h0000;
      staged              <= 8'h00;
      new_coefficient_set <= 1'b0;
      for (int k = 0; k < NUM_COEFF; k++) coeff[k] <= 16'h0000;
    end else begin
      result_q <= fir_out;
      if (stage_wr) staged <= hwdata[7:0];
      for (int k = 0; k < NUM_COEFF; k++)
        if (commit && hidx_p1 == 32'(COEF_HIDX + k))
          coeff[k] <= lane_merge(coeff[k], hwdata, size_p1, addr_p1[0]);
      if (conf_set)                   new_coefficient_set <= 1'b1;
      else if (clear_new_coefficient) new_coefficient_set <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ahb_fir_slave_param.sv
// Bench for ahb_fir_slave_param: vector table plus hand sequences for wait-state, error and pipelining cases.
module tb_ahb_fir_slave_param;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        hsel;
  logic [4:0]  haddr;
  logic        hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [15:0] hwdata;
  logic [15:0] hrdata;
  logic        hresp;
  logic        hready;
  logic        modwait;
  logic        err;
  logic [15:0] fir_out;
  logic [15:0] sample_data;
  logic        data_ready;
  logic        sample_ack;
  logic [1:0]  coefficient_num;
  logic [15:0] fir_coefficient;
  logic        new_coefficient_set;
  logic        clear_new_coefficient;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic        sz;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic        is_read;
    logic [15:0] rdata;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[13];

  always #5 clk = ~clk;

  ahb_fir_slave_param #(.NUM_COEFF(4), .FIFO_DEPTH(4), .ADDR_W(5)) dut (
    .clk                   (clk),
    .n_rst                 (n_rst),
    .hsel                  (hsel),
    .haddr                 (haddr),
    .hsize                 (hsize),
    .htrans                (htrans),
    .hwrite                (hwrite),
    .hwdata                (hwdata),
    .hrdata                (hrdata),
    .hresp                 (hresp),
    .hready                (hready),
    .modwait               (modwait),
    .err                   (err),
    .fir_out               (fir_out),
    .sample_data           (sample_data),
    .data_ready            (data_ready),
    .sample_ack            (sample_ack),
    .coefficient_num       (coefficient_num),
    .fir_coefficient       (fir_coefficient),
    .new_coefficient_set   (new_coefficient_set),
    .clear_new_coefficient (clear_new_coefficient)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addr_phase(input logic wr, input logic [4:0] a, input logic sz);
    hsel = 1'b1; htrans = 2'd2; hwrite = wr; haddr = a; hsize = sz;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0;
  endtask

  // One non-pipelined transfer; expectation queued at the address phase, checked at completion.
  task automatic xfer(input string name, input logic wr, input logic [4:0] a, input logic sz,
                      input logic [15:0] wd, input logic [15:0] exp);
    sb_t e;
    sb_t got;
    int  waits;
    e.is_read = ~wr;
    e.rdata   = exp;
    sbq.push_back(e);
    addr_phase(wr, a, sz);
    @(posedge clk); #1;
    idle_bus();
    hwdata = wd;
    waits = 0;
    @(negedge clk);
    while (!hready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    got = sbq.pop_front();
    chk({name, "_hready"}, hready, 1'b1);
    chk({name, "_hresp"}, hresp, 1'b0);
    if (got.is_read) chk(name, hrdata, got.rdata);
    @(posedge clk); #1;
  endtask

  task automatic err_xfer(input string name, input logic wr, input logic [4:0] a, input logic sz);
    addr_phase(wr, a, sz);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk({name, "_c1"}, {hresp, hready}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_c2"}, {hresp, hready}, 2'b11);
    chk({name, "_rdata"}, hrdata, 16'h0000);
    @(posedge clk); #1;
  endtask

  initial begin
    n_rst = 1'b0; idle_bus(); haddr = '0; hsize = 1'b0; hwdata = '0;
    modwait = 1'b0; err = 1'b0; fir_out = 16'h1357; sample_ack = 1'b0;
    coefficient_num = 2'd0; clear_new_coefficient = 1'b0;

    vecs[0]  = '{1'b0, 5'h04, 1'b1, 16'h0000, 16'hBEEF};
    vecs[1]  = '{1'b1, 5'h04, 1'b0, 16'h0034, 16'h0000};
    vecs[2]  = '{1'b1, 5'h05, 1'b0, 16'h1200, 16'h0000};
    vecs[3]  = '{1'b0, 5'h00, 1'b1, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 5'h0A, 1'b1, 16'h00A5, 16'h0000};
    vecs[5]  = '{1'b0, 5'h0A, 1'b1, 16'h0000, 16'h00A5};
    vecs[6]  = '{1'b0, 5'h0B, 1'b0, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, 5'h0B, 1'b0, 16'h7700, 16'h0000};
    vecs[8]  = '{1'b0, 5'h0A, 1'b1, 16'h0000, 16'h77A5};
    vecs[9]  = '{1'b0, 5'h0B, 1'b0, 16'h0000, 16'h7700};
    vecs[10] = '{1'b1, 5'h0A, 1'b1, 16'h00A5, 16'h0000};
    vecs[11] = '{1'b0, 5'h02, 1'b1, 16'h0000, 16'h1357};
    vecs[12] = '{1'b0, 5'h0E, 1'b1, 16'h0000, 16'h0000};

    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    chk("rst_hready", hready, 1'b1);
    chk("rst_hresp", hresp, 1'b0);
    chk("rst_outs", {data_ready, sample_data, fir_coefficient, new_coefficient_set, hrdata},
        '0);
    @(posedge clk); #1;
    xfer("rd_status_reset", 1'b0, 5'h00, 1'b1, 16'h0, 16'h0004);

    xfer("wr_sample_beef", 1'b1, 5'h04, 1'b1, 16'hBEEF, 16'h0);
    @(negedge clk);
    chk("push_latency", {data_ready, sample_data}, {1'b1, 16'hBEEF});
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].sz, vecs[i].wdata, vecs[i].exp);

    coefficient_num = 2'd2;
    #1 chk("fir_coeff_sel", fir_coefficient, 16'h00A5);

    sample_ack = 1'b1; @(posedge clk); #1; sample_ack = 1'b0;
    @(negedge clk);
    chk("pop_head_1234", sample_data, 16'h1234);
    sample_ack = 1'b1; @(posedge clk); #1; sample_ack = 1'b0;
    @(negedge clk);
    chk("pop_to_empty", {data_ready, sample_data}, {1'b0, 16'h0000});
    sample_ack = 1'b1; @(posedge clk); #1; sample_ack = 1'b0;
    chk("ack_empty_ignored", data_ready, 1'b0);

    xfer("wr_conf", 1'b1, 5'h0E, 1'b1, 16'h0001, 16'h0);
    chk("ncs_set", new_coefficient_set, 1'b1);
    xfer("rd_status_ncs", 1'b0, 5'h00, 1'b1, 16'h0, 16'h0005);
    clear_new_coefficient = 1'b1;
    xfer("wr_conf_vs_clear", 1'b1, 5'h0E, 1'b1, 16'h0001, 16'h0);
    @(negedge clk);
    chk("set_wins_clear", new_coefficient_set, 1'b1);
    @(posedge clk); #1;
    clear_new_coefficient = 1'b0;
    @(negedge clk);
    chk("clear_alone", new_coefficient_set, 1'b0);
    @(posedge clk); #1;

    err_xfer("err_wr_result", 1'b1, 5'h02, 1'b1);
    err_xfer("err_half_odd", 1'b0, 5'h07, 1'b1);
    err_xfer("err_beyond_conf", 1'b0, 5'h10, 1'b0);
    hwdata = 16'hFFFF;
    err_xfer("err_wr_half_odd", 1'b1, 5'h0B, 1'b1);
    xfer("coeff2_unchanged", 1'b0, 5'h0A, 1'b1, 16'h0, 16'h00A5);

    // address phase during ERROR cycle 1 must be dropped
    hwdata = 16'hDEAD;
    addr_phase(1'b1, 5'h02, 1'b1);
    @(posedge clk); #1;
    addr_phase(1'b1, 5'h06, 1'b1);
    @(negedge clk);
    chk("err1_ignore_c1", {hresp, hready}, 2'b10);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("err1_ignore_c2", {hresp, hready}, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err1_ignore_nowait", hready, 1'b1);
    @(posedge clk); #1;
    xfer("coeff0_untouched", 1'b0, 5'h06, 1'b1, 16'h0, 16'h0000);

    for (int i = 0; i < 4; i++)
      xfer($sformatf("fill%0d", i), 1'b1, 5'h04, 1'b1, 16'(16'h1000 + i), 16'h0);
    addr_phase(1'b1, 5'h04, 1'b1);
    @(posedge clk); #1;
    idle_bus();
    hwdata = 16'h2000;
    @(negedge clk);
    chk("full_wait_c1", hready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_wait_c2", hready, 1'b0);
    @(posedge clk); #1;
    sample_ack = 1'b1;
    @(negedge clk);
    chk("full_ack_ready", hready, 1'b1);
    @(posedge clk); #1;
    sample_ack = 1'b0;
    @(negedge clk);
    chk("full_after_pushpop", sample_data, 16'h1001);
    @(posedge clk); #1;
    err = 1'b1;
    xfer("rd_status_full", 1'b0, 5'h00, 1'b1, 16'h0, 16'h0102);
    err = 1'b0;

    // back-to-back write then read of the same register
    addr_phase(1'b1, 5'h06, 1'b1);
    @(posedge clk); #1;
    addr_phase(1'b0, 5'h06, 1'b1);
    hwdata = 16'h5555;
    @(negedge clk);
    chk("b2b_wr_nowait", hready, 1'b1);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("b2b_rd_nowait", hready, 1'b1);
    chk("b2b_rd_data", hrdata, 16'h5555);
    @(posedge clk); #1;

    n_rst = 1'b0;
    #2;
    chk("reset_again", {data_ready, new_coefficient_set, fir_coefficient, hready, hresp},
        {1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    @(posedge clk); #1 n_rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
